// File: rtl/block_sum_accumulator.sv
// rtl/block_sum_accumulator.sv - sums blocks of 2^DIV_LOG2 samples for the rounding divider
module block_sum_accumulator #(
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 32,
    parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [OUT_WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 clear,
    output logic [IN_WIDTH-1:0]  sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic [DIV_LOG2-1:0]  cnt
);

    // Count value of the sample that closes a block.
    localparam logic [DIV_LOG2-1:0] LAST_CNT = '1;

    logic [IN_WIDTH-1:0] r_acc;
    logic [DIV_LOG2-1:0] r_cnt;
    logic [IN_WIDTH-1:0] r_sum;
    logic                r_sum_valid;

    logic                w_last;
    logic                w_din_ready;
    logic                w_accept;
    logic                w_complete;
    logic [IN_WIDTH-1:0] w_acc_next;

    // Handshake decode: stall only when the closing sample would overwrite a held result.
    always_comb begin
        w_last      = (r_cnt == LAST_CNT);
        w_din_ready = !clear && !(w_last && r_sum_valid && !sum_ready);
        w_accept    = din_valid && w_din_ready;
        w_complete  = w_accept && w_last;
        // Zero-extended sample; the sum width leaves room for a full block of max samples.
        w_acc_next  = r_acc + IN_WIDTH'(din);
    end

    // Partial-block accumulator and sample counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + DIV_LOG2'(1);
            end
        end
    end

    // Result register: a completion and a consume in the same cycle reload without a bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else if (w_complete) begin
            r_sum       <= w_acc_next;
            r_sum_valid <= 1'b1;
        end else if (r_sum_valid && sum_ready) begin
            r_sum_valid <= 1'b0;
        end
    end

    assign din_ready = w_din_ready;
    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;
    assign cnt       = r_cnt;

endmodule

// File: doc/block_sum_accumulator.md
Name: block_sum_accumulator

Overview:
- Upstream feeder for the rounding power-of-two divider.
- Accepts a stream of unsigned OUT_WIDTH samples and sums each block of 2^DIV_LOG2 consecutive samples.
- Presents the full-width IN_WIDTH sum, so the divider's rounded output is the block average.
- Valid/ready handshakes on both sides; a separate output register lets accumulation of the next block overlap with an unconsumed result.

Parameters:
- DIV_LOG2, default 3, log2 of block length; block = 2^DIV_LOG2 samples; must be >= 1.
- OUT_WIDTH, default 32, sample width; matches divider output width.
- IN_WIDTH, default OUT_WIDTH+DIV_LOG2, sum width; matches divider input width; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- din  in  OUT_WIDTH  unsigned sample
- din_valid  in  1  sample present
- din_ready  out  1  sample accepted when din_valid && din_ready
- clear  in  1  synchronous discard of the partial block
- sum  out  IN_WIDTH  completed block sum
- sum_valid  out  1  sum holds an unconsumed result
- sum_ready  in  1  consumer takes sum when sum_valid && sum_ready
- cnt  out  DIV_LOG2  samples accepted in the current partial block

Behaviour:
- Reset (resetn low, asynchronous): acc=0, cnt=0, sum=0, sum_valid=0. Reset mid-block or while holding a result discards everything. The first accept is allowed on the first clk edge after deassertion.
- Widths:
  - acc is IN_WIDTH bits.
  - din is zero-extended to IN_WIDTH before addition.
  - Max sum is (2^OUT_WIDTH-1)*2^DIV_LOG2 < 2^IN_WIDTH, so overflow is impossible and no saturation logic is present.
- last = (cnt == 2^DIV_LOG2-1).
- din_ready = !clear && !(last && sum_valid && !sum_ready).
  - Combinational from state, clear and sum_ready; no dependency on din_valid.
  - Stalls only when the closing sample would overwrite an unconsumed result.
- Accept, not last: acc <= acc+din; cnt <= cnt+1.
- Accept, last:
  - sum <= acc+din; sum_valid <= 1; acc <= 0; cnt <= 0.
  - Wraps to a new block with one cycle latency from the last accept to sum_valid.
- Output handshake:
  - If sum_valid && sum_ready and no new completion in the same cycle: sum_valid <= 0; sum retains its value.
  - Simultaneous consume and completion: sum loads the new value and sum_valid stays 1, giving back-to-back blocks without a bubble.
- While sum_valid && !sum_ready: sum and sum_valid are held stable.
- clear high: acc <= 0, cnt <= 0, and no sample is accepted that cycle (din_ready=0). sum and sum_valid are unaffected, and the output handshake proceeds normally.
- No input accepted: acc and cnt hold.
- Sustained throughput: one sample per cycle whenever the consumer keeps sum_ready high.

Test Plan:
- (OUT_WIDTH=8, DIV_LOG2=2 throughout.)
- Reset: assert resetn=0 mid-block with cnt=2 and sum_valid=1 -> immediately cnt=0, sum_valid=0, sum=0; after release, 4 samples of 1 -> sum=4.
- Basic block: din 10,20,30,41 on consecutive cycles, sum_ready=1 -> sum=101 (0x065) with sum_valid high for exactly one cycle, one cycle after the 41 is accepted; cnt sequence 0,1,2,3,0.
- Max value: four samples of 255 -> sum=1020 (0x3FC), no wrap; fed to the divider, the result is 255.
- Backpressure:
  - Stimulus: sum_ready=0 after block A (sum=4), then stream block B samples 2,2,2,2.
  - Required: first three accepted; the fourth sees din_ready=0 while sum=4 is held.
  - Then raise sum_ready: fourth accepted that cycle, next cycle sum=8 with sum_valid still 1.
- Clear:
  - Accept 5,5, then clear=1 with din_valid=1 -> din_ready=0, cnt->0.
  - Then 1,1,1,1 -> sum=4; a held result from before the clear survives untouched.
- Back-to-back: 8 samples of 7 with sum_ready=1 -> two results of 28 on consecutive-block completions, no input stall cycles.
